uart_tx_mmio: RTL and testbench
===============================

// Module: uart_tx_mmio
// PURPOSE
// - Memory-mapped UART transmitter; CPU-to-host counterpart of the UART receive word read by the data-memory decoder at 0x4000.
// - CPU stores to TX_ADDR push bytes into a small FIFO.
// - Bytes are serialized 8N1, LSB first, on the tx pin.
// - A status word at STAT_ADDR lets firmware poll for space and for completion.
// PARAMETERS
// - CLK_FREQ    50_000_000  system clock in Hz
// - BAUD        115_200     line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 2)
// - TX_ADDR     32'h4004    write-only data register; byte taken from WriteData[7:0]
// - STAT_ADDR   32'h4008    read status; write with bit0=1 clears overflow
// - FIFO_DEPTH  8           bytes buffered; power of two, >= 2
// PORTS
// - clk        in   1   system clock; all state updates on posedge
// - rst        in   1   reset, asynchronous, active-high
// - MemWrite   in   1   store strobe from the datapath, same cycle as A/WriteData
// - A          in   32  byte address from the ALU
// - WriteData  in   32  store data
// - stat_data  out  32  status word, combinational from registered state
// - tx         out  1   serial line, idle high, registered
// - tx_busy    out  1   1 while the FIFO is non-empty or a frame is in flight
// BEHAVIOUR
// - Reset values (async, immediate):
//   - tx=1, tx_busy=0
//   - FIFO empty, count=0
//   - overflow=0, state=IDLE
//   - baud counter 0, bit index 0
// - Push: on a posedge with MemWrite && A==TX_ADDR, WriteData[7:0] is written at the FIFO tail.
//   - Accepted when !full, or when a pop occurs in the same cycle.
//   - Otherwise the byte is dropped and overflow is set (sticky).
// - Overflow clear: MemWrite && A==STAT_ADDR && WriteData[0] clears overflow.
//   - A drop in the same cycle wins: overflow stays 1.
// - Other addresses are ignored entirely; no side effects.
// - FSM tx_state_t, one of {IDLE, START, DATA, STOP}:
//   - IDLE: tx=1. If !empty, pop head into shift reg and go to START (tx=0 from this edge).
//   - START: hold CLKS_PER_BIT cycles, then go to DATA, bit index 0, tx=shift[0].
//   - DATA: each bit is held CLKS_PER_BIT cycles, then shift right.
//     - After bit index 7 completes, go to STOP with tx=1.
//   - STOP: hold CLKS_PER_BIT cycles, then go to IDLE.
// - Back-to-back frames: if STOP completes with FIFO non-empty, go directly to START with the next byte.
//   - No idle gap; each frame is exactly 10*CLKS_PER_BIT cycles.
// - Latency: byte accepted at edge E0 into an empty FIFO in IDLE gives tx falling at edge E1.
// - Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state or bit change.
// - stat_data layout:
//   - [0] tx_busy, [1] full, [2] empty, [3] overflow
//   - [15:8] count (zero-extended)
//   - all other bits 0
// - Count update: count += push_ok - pop. A simultaneous push and pop leaves count unchanged.
// - Wrap-around: head and tail pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//   - full/empty come from count, not from pointer compare.
// - Reset mid-frame: tx returns high asynchronously and the partial frame is abandoned; no resume.
// STRUCTURE
// - Package uart_pkg:
//   - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}
//   - localparams UART_RX_ADDR=32'h4000, UART_TX_ADDR=32'h4004, UART_STAT_ADDR=32'h4008
//   - function clks_per_bit(clk_freq, baud)
// - Sub-module uart_tx_fifo (DEPTH, WIDTH=8):
//   - ports clk, rst, push, din, pop, dout, full, empty, count
//   - dout is the head, valid while !empty
// - Top level holds the address decode, the overflow flag, the FSM, the baud counter and the shift register.
// TESTING (CLK_FREQ=50_000_000, BAUD=5_000_000 -> CLKS_PER_BIT=10)
// - Single byte: write 0x55 to 0x4004.
//   - tx falls 1 cycle later: 0 for 10 clks, then bits 1,0,1,0,1,0,1,0 at 10 clks each, then 1 for 10 clks.
//   - tx_busy drops after 100 clks.
// - Burst: 3 consecutive writes 0xA5,0x00,0xFF -> three contiguous 100-clk frames, no gap.
//   - Bench UART model decodes A5,00,FF.
// - Full/overflow: 9 writes while the first frame is in flight.
//   - stat_data[1]=1, stat_data[3]=1, count=8.
//   - 9th byte is never transmitted.
//   - A write of 0x1 to 0x4008 then clears bit3.
// - Push+pop when full: FIFO full, write lands on the IDLE pop edge -> accepted, count stays 8, overflow stays 0.
// - Address filter: writes to 0x4000, 0x1000, 0x4005 -> tx stays 1, count 0, stat_data=32'h0000_0004.
// - Reset mid-frame: assert rst during DATA bit 3.
//   - tx=1 immediately, stat_data=32'h0000_0004.
//   - A new write after release gives a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, address map and baud helper for the memory-mapped UART
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [31:0] UART_RX_ADDR   = 32'h4000;
  localparam logic [31:0] UART_TX_ADDR   = 32'h4004;
  localparam logic [31:0] UART_STAT_ADDR = 32'h4008;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO holding bytes queued for the UART transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  // Storage carries no reset; only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem_q[head_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status word
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter logic [31:0] TX_ADDR    = UART_TX_ADDR,
  parameter logic [31:0] STAT_ADDR  = UART_STAT_ADDR,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] A,
  input  logic [31:0] WriteData,
  output logic [31:0] stat_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(CPB);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          fifo_pop;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  logic wr_tx, wr_clr, drop, baud_done;
  logic unused_wdata;

  assign wr_tx     = MemWrite && (A == TX_ADDR);
  assign wr_clr    = MemWrite && (A == STAT_ADDR) && WriteData[0];
  // A pop on the same edge frees the slot, so a write into a full FIFO still lands.
  assign fifo_push = wr_tx && (!fifo_full || fifo_pop);
  assign drop      = wr_tx && fifo_full && !fifo_pop;
  assign baud_done = (baud_q == BW'(CPB - 1));
  assign unused_wdata = ^WriteData[31:8];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (WriteData[7:0]),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next frame so back-to-back bytes leave no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drop beats clear so a lost byte is never hidden by a clear in the same cycle.
  assign ovf_d = drop ? 1'b1 : (wr_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx        = tx_q;
  assign tx_busy   = (state_q != IDLE) || !fifo_empty;
  assign stat_data = {16'h0000, 8'(fifo_count), 4'h0, ovf_q, fifo_empty, fifo_full, tx_busy};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench: bus stimulus queues bytes, a line decoder checks frames
module tb_uart_tx_mmio;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 8;
  localparam logic [31:0] TXA = 32'h4004;
  localparam logic [31:0] STA = 32'h4008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] stat_data;
  logic        tx;
  logic        tx_busy;

  uart_tx_mmio #(
    .CLK_FREQ(50_000_000), .BAUD(5_000_000),
    .TX_ADDR(TXA), .STAT_ADDR(STA), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .A(A), .WriteData(WriteData),
    .stat_data(stat_data), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb[$];
  int         starts[$];
  int         mcnt = 0;
  logic       movf = 1'b0;
  int         n_starts = 0;
  int         rst_cnt = 0;
  int         last_wr_cyc = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input logic busy);
    logic [7:0] c;
    c = 8'(mcnt);
    return {16'h0000, c, 4'h0, movf, (mcnt == 0), (mcnt == DEPTH), busy};
  endfunction

  // Bus write issued at posedge+3; the model decides acceptance from its own occupancy count.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input bit pop_now);
    if (addr == TXA) begin
      if (mcnt < DEPTH || pop_now) begin
        sb.push_back(data[7:0]);
        mcnt++;
      end else begin
        movf = 1'b1;
      end
    end else if (addr == STA && data[0]) begin
      movf = 1'b0;
    end
    MemWrite = 1'b1; A = addr; WriteData = data;
    @(posedge clk); #1;
    last_wr_cyc = cyc;
    #2;
    MemWrite = 1'b0; A = '0; WriteData = '0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #3; end
  endtask

  task automatic wait_starts(input int n, input string name);
    int guard = 0;
    while (n_starts < n && guard < 3 * FRAME) begin @(posedge clk); #3; guard++; end
    if (n_starts < n) begin
      total++; bad++;
      $display("FAIL %s: start bits seen %0d, want %0d", name, n_starts, n);
    end
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 20 * FRAME) begin @(posedge clk); #3; guard++; end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL %s: %0d bytes never transmitted, want 0", name, sb.size());
    end
    repeat (CPB) @(posedge clk);
    #3;
  endtask

  // Line decoder: finds a falling edge, samples mid-bit, compares against the scoreboard head.
  initial begin : monitor
    logic       prev;
    logic       startb, stopb;
    logic [7:0] b, e;
    int         rc;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (prev === 1'b1 && tx === 1'b0 && !rst) begin
        rc = rst_cnt;
        starts.push_back(cyc);
        n_starts++;
        if (mcnt > 0) mcnt--;
        repeat (CPB / 2) @(posedge clk);
        #1 startb = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(posedge clk);
          #1 b[k] = tx;
        end
        repeat (CPB) @(posedge clk);
        #1 stopb = tx;
        if (rst_cnt == rc) begin
          check("start_bit", 32'(startb), 32'h0);
          check("stop_bit", 32'(stopb), 32'h1);
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame: got 0x%02h want no frame", b);
          end else begin
            e = sb.pop_front();
            check("frame_byte", 32'(b), 32'(e));
          end
        end
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    total++; bad++;
    $display("FAIL watchdog: time limit reached, want end of test");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stim
    int s, w, n0, r;
    logic tx_low;
    logic [31:0] other [5];
    other = '{32'h4000, 32'h1000, 32'h4005, 32'h400C, 32'h0000_4004 ^ 32'h8000};

    repeat (3) @(posedge clk);
    #3;
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_busy", 32'(tx_busy), 32'h0);
    check("reset_stat", stat_data, 32'h0000_0004);
    rst = 1'b0;
    @(posedge clk); #3;

    bus_write(TXA, 32'h55, 1'b0);
    w = last_wr_cyc;
    wait_starts(1, "single_start");
    s = starts[$];
    check("single_latency", 32'(s - w), 32'd1);
    wait_cyc(s + FRAME - 1);
    check("single_busy_stop", 32'(tx_busy), 32'h1);
    check("single_stop_level", 32'(tx), 32'h1);
    wait_cyc(s + FRAME);
    check("single_busy_drop", 32'(tx_busy), 32'h0);
    wait_drain("single_drain");
    check("single_stat", stat_data, exp_stat(1'b0));

    n0 = n_starts;
    bus_write(TXA, 32'hA5, 1'b0);
    bus_write(TXA, 32'h00, 1'b0);
    bus_write(TXA, 32'hFF, 1'b0);
    wait_starts(n0 + 3, "burst_start");
    wait_drain("burst_drain");
    if (starts.size() >= n0 + 3) begin
      check("burst_gap1", 32'(starts[n0 + 1] - starts[n0]), 32'(FRAME));
      check("burst_gap2", 32'(starts[n0 + 2] - starts[n0 + 1]), 32'(FRAME));
    end
    check("burst_stat", stat_data, exp_stat(1'b0));

    n0 = n_starts;
    bus_write(TXA, 32'h11, 1'b0);
    wait_starts(n0 + 1, "ovf_start");
    s = starts[$];
    for (int i = 0; i < 9; i++) bus_write(TXA, 32'($urandom_range(0, 255)), 1'b0);
    check("ovf_stat", stat_data, exp_stat(1'b1));
    check("ovf_stat_const", stat_data, 32'h0000_080B);
    bus_write(STA, 32'h1, 1'b0);
    check("ovf_clear", stat_data, 32'h0000_0803);
    wait_cyc(s + FRAME - 1);
    bus_write(TXA, 32'h9C, 1'b1);
    check("pushpop_full", stat_data, exp_stat(1'b1));
    check("pushpop_const", stat_data, 32'h0000_0803);
    wait_drain("ovf_drain");
    check("ovf_end_stat", stat_data, exp_stat(1'b0));

    n0 = n_starts;
    bus_write(32'h4000, 32'h5A, 1'b0);
    bus_write(32'h1000, 32'hFF, 1'b0);
    bus_write(32'h4005, 32'h01, 1'b0);
    tx_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #3;
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    check("addr_tx_idle", 32'(tx_low), 32'h0);
    check("addr_stat", stat_data, 32'h0000_0004);
    check("addr_no_frame", 32'(n_starts), 32'(n0));

    n0 = n_starts;
    bus_write(TXA, 32'hC3, 1'b0);
    wait_starts(n0 + 1, "rst_frame_start");
    s = starts[$];
    wait_cyc(s + 4 * CPB + 4);
    check("rst_pre_bit3", 32'(tx), 32'h0);
    rst = 1'b1;
    rst_cnt++;
    sb.delete();
    mcnt = 0;
    movf = 1'b0;
    #1;
    check("rst_tx_async", 32'(tx), 32'h1);
    check("rst_stat_async", stat_data, 32'h0000_0004);
    check("rst_busy_async", 32'(tx_busy), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    wait_cyc(cyc + FRAME + 10);
    n0 = n_starts;
    bus_write(TXA, 32'h3C, 1'b0);
    wait_starts(n0 + 1, "rst_new_start");
    wait_drain("rst_drain");
    check("rst_end_stat", stat_data, exp_stat(1'b0));

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        if (mcnt < DEPTH) bus_write(TXA, $urandom, 1'b0);
        else begin @(posedge clk); #3; end
      end else if (r < 7) begin
        bus_write(other[$urandom_range(0, 4)], $urandom, 1'b0);
      end else if (r == 7) begin
        bus_write(STA, $urandom, 1'b0);
      end else begin
        repeat ($urandom_range(1, 150)) @(posedge clk);
        #3;
      end
    end
    wait_drain("rand_drain");
    check("rand_end_stat", stat_data, exp_stat(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
